demux8_burst_sched: RTL and testbench

- Scheduler that drives the 1-to-8 demux path and shares one upstream valid/ready stream across 8 downstream channels.
- Grants channels round-robin in bursts of up to BURST_LEN beats, skipping disabled or not-ready channels.
- Drives a registered 3-bit select plus one-hot channel valids.
- Sits between a single producer and eight consumers.

---
 rtl/demux8_pkg.sv | 26 ++
 rtl/rr_pick8.sv | 13 +
 rtl/demux8_burst_sched.sv | 139 +++++++++++++
 tb/tb_demux8_burst_sched.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux8_pkg.sv
// Shared types and helpers for the 8-channel demux scheduler and its arbiters.
package demux8_pkg;

  localparam int NUM_CH = 8;
  localparam int SEL_W  = 3;

  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } state_t;

  // Returns {found, idx}: first set bit of mask scanning ptr, ptr+1, ... with wrap.
  function automatic logic [SEL_W:0] rr_pick(input logic [NUM_CH-1:0] mask,
                                             input logic [SEL_W-1:0]  ptr);
    logic [SEL_W:0]   res;
    logic [SEL_W-1:0] idx;
    res = '0;
    // Walk from the farthest offset down so the nearest hit is written last.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = ptr + SEL_W'(i);
      if (mask[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotate-priority encoder over an 8-bit request mask.
module rr_pick8
  import demux8_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  ptr,
  output logic              found,
  output logic [SEL_W-1:0]  idx
);

  assign {found, idx} = rr_pick(mask, ptr);

endmodule

// File: rtl/demux8_burst_sched.sv
// Round-robin burst scheduler sharing one valid/ready stream across 8 channels.
// Optional per-channel beat counters are built when DEMUX8_SCHED_STATS_EN is defined.
//
// state | meaning
// ARB   | pick next eligible channel from ptr; no data moves
// XFER  | granted channel sel owns the stream until the last beat of its burst
module demux8_burst_sched
  import demux8_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] chan_en,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [NUM_CH-1:0] out_ready,
  output logic [NUM_CH-1:0] out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  sel,
  output logic              busy,
`ifdef DEMUX8_SCHED_STATS_EN
  input  logic [SEL_W-1:0]  stat_idx,
  input  logic              stat_clr,
  output logic [15:0]       stat_cnt,
`endif
  output logic              burst_done
);

  localparam int                CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BURST_LEN - 1);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             busy_q, busy_d;

  logic             win_found;
  logic [SEL_W-1:0] win_idx;
  logic             beat;
  logic             last_beat;

  rr_pick8 u_pick (
    .mask  (chan_en & out_ready),
    .ptr   (ptr_q),
    .found (win_found),
    .idx   (win_idx)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    sel_d      = sel_q;
    beat_cnt_d = beat_cnt_q;
    busy_d     = busy_q;
    in_ready   = 1'b0;
    out_valid  = '0;
    out_data   = '0;
    beat       = 1'b0;
    last_beat  = 1'b0;
    case (state_q)
      ARB: begin
        if (in_valid && win_found) begin
          sel_d      = win_idx;
          beat_cnt_d = '0;
          busy_d     = 1'b1;
          state_d    = XFER;
        end
      end
      XFER: begin
        in_ready           = out_ready[sel_q];
        out_valid[sel_q]   = in_valid;
        out_data           = in_data;
        beat               = in_valid && out_ready[sel_q];
        last_beat          = beat && ((beat_cnt_q == CNT_LAST) || in_last);
        if (last_beat) begin
          beat_cnt_d = '0;
          ptr_d      = sel_q + SEL_W'(1);
          busy_d     = 1'b0;
          state_d    = ARB;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB;
      ptr_q      <= '0;
      sel_q      <= '0;
      beat_cnt_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      sel_q      <= sel_d;
      beat_cnt_q <= beat_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign burst_done = last_beat;

`ifdef DEMUX8_SCHED_STATS_EN
  logic [15:0] stat_q [NUM_CH];
  logic [15:0] stat_d [NUM_CH];

  // Clear wins over a same-cycle beat; counters stick at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clr)
        stat_d[i] = '0;
      else if (beat && (sel_q == SEL_W'(i)) && (stat_q[i] != 16'hFFFF))
        stat_d[i] = stat_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) stat_q[i] <= stat_d[i];
    end
  end

  assign stat_cnt = stat_q[stat_idx];
`endif

endmodule

// File: tb/tb_demux8_burst_sched.sv
// Directed bench for demux8_burst_sched (BURST_LEN=4); stats checks build with DEMUX8_SCHED_STATS_EN.
module tb_demux8_burst_sched;

  logic       clk;
  logic       rst;
  logic [7:0] chan_en;
  logic       in_valid;
  logic       in_last;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] out_ready;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [2:0] sel;
  logic       busy;
  logic       burst_done;
`ifdef DEMUX8_SCHED_STATS_EN
  logic [2:0]  stat_idx;
  logic        stat_clr;
  logic [15:0] stat_cnt;
`endif

  int checks = 0;
  int errors = 0;

  demux8_burst_sched #(.DATA_W(8), .BURST_LEN(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .chan_en    (chan_en),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .sel        (sel),
    .busy       (busy),
`ifdef DEMUX8_SCHED_STATS_EN
    .stat_idx   (stat_idx),
    .stat_clr   (stat_clr),
    .stat_cnt   (stat_cnt),
`endif
    .burst_done (burst_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    chan_en = 8'hFF; in_valid = 1'b1; in_last = 1'b0; in_data = 8'h3C; out_ready = 8'hFF;
`ifdef DEMUX8_SCHED_STATS_EN
    stat_idx = 3'd0; stat_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, sel, in_ready, out_valid, out_data, burst_done} !== 22'd0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b sel=%0d in_ready=%b out_valid=%h out_data=%h burst_done=%b, required all 0",
               busy, sel, in_ready, out_valid, out_data, burst_done);
    end
    in_valid = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  // Full mask, continuous traffic: grants 0..7,0 with 4 beats + 1 ARB cycle each.
  task automatic test_round_robin;
    logic [2:0] exp_sel;
    logic       exp_busy;
    chan_en = 8'hFF; out_ready = 8'hFF; in_valid = 1'b1; in_last = 1'b0;
    for (int c = 0; c < 45; c++) begin
      if (c > 0) tick();
      in_data = 8'(c * 7 + 1);
      #1;
      exp_busy = (c % 5) != 0;
      exp_sel  = 3'((c / 5) % 8);
      checks++;
      if (busy !== exp_busy) begin
        errors++; $display("FAIL rr_busy c=%0d: got %b want %b", c, busy, exp_busy);
      end
      checks++;
      if (burst_done !== ((c % 5) == 4)) begin
        errors++; $display("FAIL rr_burst_done c=%0d: got %b want %b", c, burst_done, (c % 5) == 4);
      end
      checks++;
      if (out_valid !== (exp_busy ? (8'h01 << exp_sel) : 8'h00)) begin
        errors++; $display("FAIL rr_out_valid c=%0d: got %h want %h", c, out_valid,
                           exp_busy ? (8'h01 << exp_sel) : 8'h00);
      end
      checks++;
      if (out_data !== (exp_busy ? in_data : 8'h00)) begin
        errors++; $display("FAIL rr_out_data c=%0d: got %h want %h", c, out_data, exp_busy ? in_data : 8'h00);
      end
      if (exp_busy) begin
        checks++;
        if (sel !== exp_sel) begin
          errors++; $display("FAIL rr_sel c=%0d: got %0d want %0d", c, sel, exp_sel);
        end
      end
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL rr_end_idle: busy got %b want 0", busy);
    end
  endtask

  // ptr=1, only channels 0 and 7 enabled: grants 7, 0, 7.
  task automatic test_skip_wrap;
    logic [2:0] seq [3];
    logic [2:0] exp_sel;
    logic       exp_busy;
    seq[0] = 3'd7; seq[1] = 3'd0; seq[2] = 3'd7;
    chan_en = 8'h81; out_ready = 8'hFF; in_valid = 1'b1; in_last = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (c > 0) tick();
      #1;
      exp_busy = (c % 5) != 0;
      exp_sel  = seq[c / 5];
      checks++;
      if (out_valid !== (exp_busy ? (8'h01 << exp_sel) : 8'h00)) begin
        errors++; $display("FAIL skip_out_valid c=%0d: got %h want %h", c, out_valid,
                           exp_busy ? (8'h01 << exp_sel) : 8'h00);
      end
      if (exp_busy) begin
        checks++;
        if (sel !== exp_sel) begin
          errors++; $display("FAIL skip_sel c=%0d: got %0d want %0d", c, sel, exp_sel);
        end
      end
    end
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  // Channel 3 burst closed by in_last on beat 2; next grant goes to channel 4.
  task automatic test_early_term;
    chan_en = 8'h08; out_ready = 8'hFF; in_valid = 1'b1; in_last = 1'b0;
    #1;
    tick();
    chan_en = 8'hFF;
    #1;
    checks++;
    if (sel !== 3'd3 || out_valid !== 8'h08 || burst_done !== 1'b0) begin
      errors++; $display("FAIL early_beat1: sel=%0d out_valid=%h burst_done=%b, want 3 08 0", sel, out_valid, burst_done);
    end
    tick();
    in_last = 1'b1;
    #1;
    checks++;
    if (burst_done !== 1'b1) begin
      errors++; $display("FAIL early_done: burst_done got %b want 1", burst_done);
    end
    tick();
    in_last = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 8'h00) begin
      errors++; $display("FAIL early_arb: busy=%b out_valid=%h want 0 00", busy, out_valid);
    end
    tick();
    #1;
    checks++;
    if (sel !== 3'd4 || busy !== 1'b1) begin
      errors++; $display("FAIL early_next_grant: sel=%0d busy=%b want 4 1", sel, busy);
    end
    in_last = 1'b1;
    #1;
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    #1;
  endtask

  // Channel 2 stalls after 2 beats for 10 cycles, then finishes beats 3 and 4.
  task automatic test_stall;
    chan_en = 8'h04; out_ready = 8'hFF; in_valid = 1'b1; in_last = 1'b0;
    #1;
    tick();
    tick();
    tick();
    out_ready = 8'hFB;
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0 || sel !== 3'd2 || busy !== 1'b1 || burst_done !== 1'b0 || out_valid !== 8'h04) begin
        errors++; $display("FAIL stall_hold i=%0d: in_ready=%b sel=%0d busy=%b burst_done=%b out_valid=%h, want 0 2 1 0 04",
                           i, in_ready, sel, busy, burst_done, out_valid);
      end
      tick();
    end
    out_ready = 8'hFF;
    #1;
    checks++;
    if (in_ready !== 1'b1 || burst_done !== 1'b0) begin
      errors++; $display("FAIL stall_beat3: in_ready=%b burst_done=%b want 1 0", in_ready, burst_done);
    end
    tick();
    #1;
    checks++;
    if (burst_done !== 1'b1 || sel !== 3'd2) begin
      errors++; $display("FAIL stall_beat4: burst_done=%b sel=%0d want 1 2", burst_done, sel);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL stall_end: busy got %b want 0", busy);
    end
  endtask

  // Reset during a channel-5 burst after 2 beats; next grant restarts at channel 0.
  task automatic test_reset_mid_burst;
    chan_en = 8'h20; out_ready = 8'hFF; in_valid = 1'b1; in_last = 1'b0; in_data = 8'hA5;
    #1;
    tick();
    tick();
    tick();
    checks++;
    if (sel !== 3'd5 || busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre: sel=%0d busy=%b want 5 1", sel, busy);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, sel, in_ready, out_valid, out_data, burst_done} !== 22'd0) begin
      errors++; $display("FAIL rstmid_async: busy=%b sel=%0d in_ready=%b out_valid=%h out_data=%h burst_done=%b, want all 0",
                         busy, sel, in_ready, out_valid, out_data, burst_done);
    end
    rst = 1'b0;
    chan_en = 8'hFF;
    #1;
    tick();
    #1;
    checks++;
    if (sel !== 3'd0 || out_valid !== 8'h01 || busy !== 1'b1) begin
      errors++; $display("FAIL rstmid_regrant: sel=%0d out_valid=%h busy=%b want 0 01 1", sel, out_valid, busy);
    end
    in_last = 1'b1;
    #1;
    checks++;
    if (burst_done !== 1'b1) begin
      errors++; $display("FAIL rstmid_done: burst_done got %b want 1", burst_done);
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    #1;
  endtask

`ifdef DEMUX8_SCHED_STATS_EN
  // 6 beats to channel 1 (burst of 4, then 2 ending on in_last), read, then clear.
  task automatic test_stats;
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    chan_en = 8'h02; out_ready = 8'hFF; in_valid = 1'b1; in_last = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) tick();
      in_last = (c == 7);
      #1;
    end
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    stat_idx = 3'd1;
    #1;
    checks++;
    if (stat_cnt !== 16'd6) begin
      errors++; $display("FAIL stats_ch1: got %0d want 6", stat_cnt);
    end
    stat_idx = 3'd0;
    #1;
    checks++;
    if (stat_cnt !== 16'd0) begin
      errors++; $display("FAIL stats_ch0: got %0d want 0", stat_cnt);
    end
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    stat_idx = 3'd1;
    #1;
    checks++;
    if (stat_cnt !== 16'd0) begin
      errors++; $display("FAIL stats_clear: got %0d want 0", stat_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_skip_wrap();
    test_early_term();
    test_stall();
    test_reset_mid_burst();
`ifdef DEMUX8_SCHED_STATS_EN
    test_stats();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
